// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: turns a UART byte stream of 'W'/'R' commands into single
// 32-bit Wishbone cycles and streams the response bytes back out.
module uart_wb_bridge #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rx_valid_i,
  input  logic [7:0]               rx_data_i,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic                     wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  output logic                     busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic                     err_q, err_d;
  logic [1:0]               cnt_q, cnt_d;   // byte index while parsing and responding
  logic [15:0]              tmo_q, tmo_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;

  // State and datapath registers; reset drops any in-flight bus cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Command parser, bus sequencer with timeout, and response byte stepping.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid_i && (rx_data_i == 8'h57 || rx_data_i == 8'h52)) begin
          we_d    = (rx_data_i == 8'h57);
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid_i) begin
          addr_d[8*cnt_q +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              tmo_d   = '0;
              err_d   = 1'b0;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_valid_i) begin
          wdata_d[8*cnt_q +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            tmo_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      S_BUS: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (wb_ack_i) begin
          if (!we_q) rdata_d = wb_data_i;
          cnt_d   = '0;
          state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RESP: begin
        if (tx_ready_i) begin
          if (err_q || we_q || cnt_q == 2'd3) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, so nothing from an input reaches them.
  assign wb_cyc_o   = (state_q == S_BUS);
  assign wb_stb_o   = (state_q == S_BUS);
  assign wb_we_o    = (state_q == S_BUS) && we_q;
  assign wb_sel_o   = (state_q == S_BUS) ? {WB_SEL_WIDTH{1'b1}} : '0;
  assign wb_addr_o  = addr_q;
  assign wb_data_o  = wdata_q;
  assign busy_o     = (state_q != S_IDLE);
  assign tx_valid_o = (state_q == S_RESP);
  assign tx_data_o  = (state_q != S_RESP) ? 8'h00 :
                      err_q               ? 8'h45 :
                      we_q                ? 8'h4B : rdata_q[8*cnt_q +: 8];

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: drives random and directed commands, acts as the
// Wishbone slave, and checks bus cycles and response bytes against a model.
module tb_uart_wb_bridge;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, busy_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;

  int nvec = 0;
  int nerr = 0;

  uart_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_data_i(wb_data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time exceeded, got hang, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input bit we, input logic [31:0] a, input logic [31:0] d);
    send_byte(we ? 8'h57 : 8'h52);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    if (we) for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_cyc"}, {31'd0, wb_cyc_o}, 0);
    chk({tag, "_stb"}, {31'd0, wb_stb_o}, 0);
    chk({tag, "_we"},  {31'd0, wb_we_o}, 0);
    chk({tag, "_sel"}, {28'd0, wb_sel_o}, 0);
    chk({tag, "_txv"}, {31'd0, tx_valid_o}, 0);
    chk({tag, "_txd"}, {24'd0, tx_data_o}, 0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 0);
  endtask

  // One full command. dly = strobe cycle (1-based) that gets ack; 0 = never.
  // d is write data for writes and slave read data for reads.
  task automatic run_cmd(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input int dly, input int stall, input bit gbus, input int npre);
    logic [7:0] exp[$];
    logic [7:0] g;
    int n, exp_cyc;
    bit ok;
    for (int i = 0; i < npre; i++) begin
      do g = 8'($urandom); while (g == 8'h57 || g == 8'h52);
      send_byte(g);
    end
    send_cmd(we, a, d);
    ok      = (dly >= 1) && (dly <= TMO);
    exp_cyc = ok ? dly : TMO;
    if (!ok)     exp.push_back(8'h45);
    else if (we) exp.push_back(8'h4B);
    else for (int k = 0; k < 4; k++) exp.push_back(d[8*k +: 8]);

    chk("cyc_first", {31'd0, wb_cyc_o}, 1);
    n = 0;
    while (wb_cyc_o && n < 100) begin
      chk("bus_addr", wb_addr_o, a);
      chk("bus_we",   {31'd0, wb_we_o}, {31'd0, we});
      chk("bus_sel",  {28'd0, wb_sel_o}, 32'hF);
      chk("bus_stb",  {31'd0, wb_stb_o}, 1);
      if (we) chk("bus_wdata", wb_data_o, d);
      wb_ack_i  = (n + 1 == dly);
      wb_data_i = wb_ack_i ? d : $urandom;
      if (gbus) begin
        rx_valid_i = 1'($urandom_range(0, 1));
        rx_data_i  = (n % 2 == 0) ? 8'h57 : 8'h52;
      end
      tick();
      n++;
    end
    wb_ack_i   = 1'b0;
    rx_valid_i = 1'b0;
    chk("cyc_len", n, exp_cyc);

    chk("txv_first", {31'd0, tx_valid_o}, 1);
    for (int s = 0; s < stall; s++) begin
      tx_ready_i = 1'b0;
      chk("stall_txv", {31'd0, tx_valid_o}, 1);
      chk("stall_txd", {24'd0, tx_data_o}, {24'd0, exp[0]});
      tick();
    end
    n = 0;
    while (exp.size() > 0 && n < 200) begin
      chk("resp_txv", {31'd0, tx_valid_o}, 1);
      if (!tx_valid_o) break;
      tx_ready_i = 1'($urandom_range(0, 3) != 0);
      chk("resp_txd", {24'd0, tx_data_o}, {24'd0, exp[0]});
      if (tx_ready_i) void'(exp.pop_front());
      tick();
      n++;
    end
    tx_ready_i = 1'b0;
    chk("resp_left", exp.size(), 0);
    chk("end_txv",  {31'd0, tx_valid_o}, 0);
    chk("end_busy", {31'd0, busy_o}, 0);
    chk("end_cyc",  {31'd0, wb_cyc_o}, 0);
  endtask

  // Start a read, reset either while strobing or while holding a response.
  task automatic reset_mid(input bit in_resp);
    send_cmd(1'b0, $urandom, 32'h0);
    if (in_resp) begin
      wb_ack_i  = 1'b1;
      wb_data_i = $urandom;
      tick();
      wb_ack_i = 1'b0;
      tick();
      chk("prerst_txv", {31'd0, tx_valid_o}, 1);
    end else begin
      tick();
      tick();
      chk("prerst_cyc", {31'd0, wb_cyc_o}, 1);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_idle_zero(in_resp ? "rst_resp" : "rst_bus");
    chk("rst_addr", wb_addr_o, 0);
    chk("rst_wdata", wb_data_o, 0);
  endtask

  initial begin
    wb_data_i = '0;
    tick();
    tick();
    chk_idle_zero("reset");
    chk("reset_addr", wb_addr_o, 0);
    chk("reset_wdata", wb_data_o, 0);
    rst_i = 1'b0;
    tick();

    // Write, ack on the 3rd strobe.
    run_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3, 0, 1'b0, 0);
    // Read, immediate ack.
    run_cmd(1'b0, 32'h0000_0004, 32'h1234_5678, 1, 0, 1'b0, 0);
    // Never acked: timeout error.
    run_cmd(1'b0, 32'hF000_0000, 32'h0, 0, 0, 1'b0, 0);
    // Garbage prefix and long tx stall.
    send_byte(8'hAA);
    run_cmd(1'b0, 32'h0000_0040, 32'hA1B2_C3D4, 2, 20, 1'b0, 0);
    // Bytes injected during BUS, then a clean command.
    run_cmd(1'b0, 32'h0000_0080, 32'h0BAD_F00D, 6, 0, 1'b1, 0);
    run_cmd(1'b1, 32'h0000_0084, 32'h1122_3344, 2, 0, 1'b0, 0);
    // Ack on the final permitted cycle wins over timeout.
    run_cmd(1'b1, 32'h0000_2000, 32'hCAFE_0001, TMO, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h0000_2004, 32'h8765_4321, TMO, 0, 1'b0, 0);
    // Reset mid-operation, then a normal write.
    reset_mid(1'b0);
    reset_mid(1'b1);
    run_cmd(1'b1, 32'h0000_3000, 32'h5555_AAAA, 1, 0, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, TMO + 2), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
